// File: rtl/flash_read_scheduler_if.sv
// Host request and spi_flash_read chunk bundle for flash_read_scheduler.
// master = host/reader side, slave = the scheduler.
interface flash_read_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_start_addr;
  logic [31:0] req_end_addr;
  logic [1:0]  req_mode;
  logic [31:0] sfr_start_addr;
  logic [31:0] sfr_end_addr;
  logic [1:0]  sfr_mode;
  logic        sfr_start_flag;
  logic        sfr_switch_die;
  logic        sfr_read_finish;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] chunk_count;

  modport master (
    output req_valid, req_start_addr, req_end_addr, req_mode, sfr_read_finish,
    input  req_ready, sfr_start_addr, sfr_end_addr, sfr_mode, sfr_start_flag,
           sfr_switch_die, busy, done, err, chunk_count
  );

  modport slave (
    input  req_valid, req_start_addr, req_end_addr, req_mode, sfr_read_finish,
    output req_ready, sfr_start_addr, sfr_end_addr, sfr_mode, sfr_start_flag,
           sfr_switch_die, busy, done, err, chunk_count
  );
endinterface

// File: rtl/flash_read_scheduler.sv
// Splits one host read into aligned, die-safe chunks for spi_flash_read; >= 4 cycles/chunk plus reader latency.
// req_ready only in IDLE, one chunk in flight; optional WAIT watchdog enabled by FLASH_SCHED_TIMEOUT_EN.
module flash_read_scheduler #(
  parameter int CHUNK_LOG2 = 8,
  parameter int DIE_LOG2   = 25
`ifdef FLASH_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                 system_clk,
  input  logic                 system_reset_n,
  flash_read_scheduler_if.slave bus
);
  localparam logic [31:0] WIN_MASK = (32'd1 << CHUNK_LOG2) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_ISSUE, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t                 state;
  logic [31:0]            cur;
  logic [31:0]            end_addr;
  logic [31-DIE_LOG2:0]   last_die;
  logic                   fin_q;
  logic [31:0]            win_end;
  logic [31:0]            chunk_end;
  logic                   fin_rise;

`ifdef FLASH_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign win_end   = cur | WIN_MASK;
  assign chunk_end = (end_addr < win_end) ? end_addr : win_end;
  // Only a low-to-high transition counts; a level left high from before WAIT does not.
  assign fin_rise  = bus.sfr_read_finish & ~fin_q;

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state              <= S_IDLE;
      cur                <= '0;
      end_addr           <= '0;
      last_die           <= '0;
      fin_q              <= 1'b0;
      bus.req_ready      <= 1'b1;
      bus.sfr_start_addr <= '0;
      bus.sfr_end_addr   <= '0;
      bus.sfr_mode       <= '0;
      bus.sfr_start_flag <= 1'b0;
      bus.sfr_switch_die <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
      bus.chunk_count    <= '0;
`ifdef FLASH_SCHED_TIMEOUT_EN
      tmo_cnt            <= '0;
`endif
    end else begin
      fin_q              <= bus.sfr_read_finish;
      bus.done           <= 1'b0;
      bus.sfr_start_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            cur             <= bus.req_start_addr;
            end_addr        <= bus.req_end_addr;
            bus.sfr_mode    <= bus.req_mode;
            bus.chunk_count <= '0;
            bus.err         <= 1'b0;
            bus.req_ready   <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (end_addr < cur || bus.sfr_mode == 2'b11) begin
            bus.err <= 1'b1;
            state   <= S_FIN;
          end else begin
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          bus.sfr_start_addr <= cur;
          bus.sfr_end_addr   <= chunk_end;
          bus.sfr_switch_die <= (cur[31:DIE_LOG2] != last_die);
          last_die           <= cur[31:DIE_LOG2];
          bus.sfr_start_flag <= 1'b1;
          state              <= S_ISSUE;
        end
        S_ISSUE: begin
`ifdef FLASH_SCHED_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (fin_rise) begin
            state <= S_NEXT;
`ifdef FLASH_SCHED_TIMEOUT_EN
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus.err <= 1'b1;
            state   <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end
        S_NEXT: begin
          bus.chunk_count <= bus.chunk_count + 16'd1;
          // Testing for the last chunk before incrementing keeps end=0xFFFFFFFF from wrapping.
          if (bus.sfr_end_addr == end_addr) begin
            state <= S_FIN;
          end else begin
            cur   <= bus.sfr_end_addr + 32'd1;
            state <= S_CALC;
          end
        end
        S_FIN: begin
          bus.done      <= 1'b1;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_read_scheduler.sv
// Self-checking bench for flash_read_scheduler: directed table, corner sequences and randomized requests
// checked against a chunk-list reference model.
module tb_flash_read_scheduler;
  localparam int CL = 8;
  localparam int DL = 25;
  localparam longint unsigned CHUNK = 64'd1 << CL;
  localparam longint unsigned DIE   = 64'd1 << DL;

  logic system_clk = 1'b0;
  logic system_reset_n = 1'b0;

  flash_read_scheduler_if bus();

  flash_read_scheduler #(
    .CHUNK_LOG2(CL),
    .DIE_LOG2(DL)
`ifdef FLASH_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .system_clk(system_clk),
    .system_reset_n(system_reset_n),
    .bus(bus)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: expected chunk list and die-switch flags from plain window/die arithmetic.
  logic [31:0]     m_s[$];
  logic [31:0]     m_e[$];
  logic            m_sw[$];
  longint unsigned m_last_die = 0;

  function automatic void model(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                                output logic x_err);
    longint unsigned cur, we, ce, die;
    m_s.delete(); m_e.delete(); m_sw.delete();
    x_err = (e < s) || (m == 2'b11);
    if (x_err) return;
    cur = s;
    while (cur <= e) begin
      we  = (cur / CHUNK + 1) * CHUNK - 1;
      ce  = (e < we) ? e : we;
      die = cur / DIE;
      m_s.push_back(32'(cur));
      m_e.push_back(32'(ce));
      m_sw.push_back(die != m_last_die);
      m_last_die = die;
      cur = ce + 1;
    end
  endfunction

  logic [31:0] obs_s[$];
  logic [31:0] obs_e[$];
  logic        obs_sw[$];

  // Issues one request and plays spi_flash_read: finish pulses lat cycles into WAIT (never if lat<0).
  // stop_flags>0 returns one cycle after that many start_flags, leaving the DUT in WAIT.
  task automatic run_req(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                         input int lat, input int stop_flags, input bit use_model,
                         output logic got_err, output int got_cnt, output int k_done);
    logic x_err;
    int   wcnt;
    bit   waiting;
    bit   stopped;
    int   n;
    obs_s.delete(); obs_e.delete(); obs_sw.delete();
    model(s, e, m, x_err);
    got_err = 1'b0; got_cnt = 0; k_done = -1; waiting = 0; wcnt = 0; stopped = 0;
    @(negedge system_clk);
    bus.req_valid = 1'b1; bus.req_start_addr = s; bus.req_end_addr = e; bus.req_mode = m;
    @(posedge system_clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge system_clk);
      if (k == 0) begin
        check("busy_after_accept", bus.busy, 1);
        check("ready_after_accept", bus.req_ready, 0);
      end
      if (bus.sfr_read_finish) bus.sfr_read_finish = 1'b0;
      else if (waiting && lat >= 0) begin
        if (wcnt == 0) begin bus.sfr_read_finish = 1'b1; waiting = 0; end
        else wcnt--;
      end
      if (bus.sfr_start_flag) begin
        obs_s.push_back(bus.sfr_start_addr);
        obs_e.push_back(bus.sfr_end_addr);
        obs_sw.push_back(bus.sfr_switch_die);
        check("sfr_mode", bus.sfr_mode, m);
        waiting = 1; wcnt = lat;
        if (stop_flags > 0 && obs_s.size() == stop_flags) begin
          @(negedge system_clk);
          stopped = 1;
          break;
        end
      end
      if (bus.done) begin
        got_err = bus.err; got_cnt = bus.chunk_count; k_done = k;
        check("ready_at_done", bus.req_ready, 1);
        break;
      end
    end
    if (stopped) return;
    check("done_seen", k_done >= 0, 1);
    if (!use_model) return;
    n = m_s.size();
    check("err", got_err, x_err);
    check("chunk_count", got_cnt, n);
    check("start_flags", obs_s.size(), n);
    for (int j = 0; j < n && j < obs_s.size(); j++) begin
      check($sformatf("chunk%0d_start", j), obs_s[j], m_s[j]);
      check($sformatf("chunk%0d_end", j), obs_e[j], m_e[j]);
      check($sformatf("chunk%0d_switch_die", j), obs_sw[j], m_sw[j]);
    end
    check("done_latency", k_done, x_err ? 2 : 2 + n * (4 + lat));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_start_flag"}, bus.sfr_start_flag, 0);
    check({tag, "_switch_die"}, bus.sfr_switch_die, 0);
    check({tag, "_sfr_start"}, bus.sfr_start_addr, 0);
    check({tag, "_sfr_end"}, bus.sfr_end_addr, 0);
    check({tag, "_sfr_mode"}, bus.sfr_mode, 0);
    check({tag, "_chunk_count"}, bus.chunk_count, 0);
  endtask

  typedef struct {
    logic [31:0] s, e;
    logic [1:0]  m;
    int          lat;
    logic        x_err;
    int          x_cnt;
    logic [31:0] fs, fe;
    logic        fsw;
    logic [31:0] ls, le;
    logic        lsw;
  } vec_t;

  vec_t vecs[8];
  logic got_err, xe;
  int   got_cnt, k_done;
  bit   seen;

  initial begin
    vecs[0] = '{s:32'h0, e:32'hB, m:2'd0, lat:0, x_err:0, x_cnt:1,
                fs:32'h0, fe:32'hB, fsw:0, ls:32'h0, le:32'hB, lsw:0};
    vecs[1] = '{s:32'h10F0, e:32'h120F, m:2'd1, lat:2, x_err:0, x_cnt:3,
                fs:32'h10F0, fe:32'h10FF, fsw:0, ls:32'h1200, le:32'h120F, lsw:0};
    vecs[2] = '{s:32'h01FFFFFA, e:32'h02000010, m:2'd2, lat:1, x_err:0, x_cnt:2,
                fs:32'h01FFFFFA, fe:32'h01FFFFFF, fsw:0, ls:32'h02000000, le:32'h02000010, lsw:1};
    vecs[3] = '{s:32'h10, e:32'h5, m:2'd0, lat:0, x_err:1, x_cnt:0,
                fs:0, fe:0, fsw:0, ls:0, le:0, lsw:0};
    vecs[4] = '{s:32'h0, e:32'hB, m:2'd3, lat:0, x_err:1, x_cnt:0,
                fs:0, fe:0, fsw:0, ls:0, le:0, lsw:0};
    vecs[5] = '{s:32'h5, e:32'h5, m:2'd0, lat:3, x_err:0, x_cnt:1,
                fs:32'h5, fe:32'h5, fsw:1, ls:32'h5, le:32'h5, lsw:1};
    vecs[6] = '{s:32'hFFFFFF80, e:32'hFFFFFFFF, m:2'd2, lat:0, x_err:0, x_cnt:1,
                fs:32'hFFFFFF80, fe:32'hFFFFFFFF, fsw:1, ls:32'hFFFFFF80, le:32'hFFFFFFFF, lsw:1};
    vecs[7] = '{s:32'hFFFFFE10, e:32'hFFFFFFFF, m:2'd1, lat:1, x_err:0, x_cnt:2,
                fs:32'hFFFFFE10, fe:32'hFFFFFEFF, fsw:0, ls:32'hFFFFFF00, le:32'hFFFFFFFF, lsw:0};

    bus.req_valid = 1'b0; bus.req_start_addr = '0; bus.req_end_addr = '0;
    bus.req_mode = '0; bus.sfr_read_finish = 1'b0;
    repeat (3) @(negedge system_clk);
    check_reset_vals("reset");
    system_reset_n = 1'b1;
    @(negedge system_clk);

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].lat, 0, 1, got_err, got_cnt, k_done);
      check($sformatf("vec%0d_err", i), got_err, vecs[i].x_err);
      check($sformatf("vec%0d_count", i), got_cnt, vecs[i].x_cnt);
      check($sformatf("vec%0d_flags", i), obs_s.size(), vecs[i].x_cnt);
      if (vecs[i].x_cnt > 0 && obs_s.size() > 0) begin
        check($sformatf("vec%0d_first_start", i), obs_s[0], vecs[i].fs);
        check($sformatf("vec%0d_first_end", i), obs_e[0], vecs[i].fe);
        check($sformatf("vec%0d_first_sw", i), obs_sw[0], vecs[i].fsw);
        check($sformatf("vec%0d_last_start", i), obs_s[obs_s.size()-1], vecs[i].ls);
        check($sformatf("vec%0d_last_end", i), obs_e[obs_e.size()-1], vecs[i].le);
        check($sformatf("vec%0d_last_sw", i), obs_sw[obs_sw.size()-1], vecs[i].lsw);
      end
    end

    // Finish already high when WAIT is entered must not complete the chunk.
    model(32'h20, 32'h2F, 2'd0, xe);
    @(negedge system_clk);
    bus.req_valid = 1'b1; bus.req_start_addr = 32'h20; bus.req_end_addr = 32'h2F; bus.req_mode = 2'd0;
    @(posedge system_clk);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge system_clk);
      seen = bus.sfr_start_flag;
    end
    check("early_flag_seen", seen, 1);
    bus.sfr_read_finish = 1'b1;
    repeat (4) @(negedge system_clk);
    bus.sfr_read_finish = 1'b0;
    repeat (3) @(negedge system_clk);
    check("early_still_busy", bus.busy, 1);
    check("early_not_counted", bus.chunk_count, 0);
    bus.sfr_read_finish = 1'b1;
    @(negedge system_clk);
    bus.sfr_read_finish = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge system_clk);
      if (bus.done) begin
        seen = 1;
        check("early_err", bus.err, 0);
        check("early_count", bus.chunk_count, 1);
      end
    end
    check("early_done_seen", seen, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] s, e;
      logic [1:0]  m;
      int          lat;
      case ($urandom_range(0, 3))
        0: s = ($urandom_range(0, 127) << DL) - $urandom_range(0, 300);
        1: s = $urandom();
        2: s = $urandom() & 32'hFFFF_FF00;
        default: s = 32'hFFFFFFFF - $urandom_range(0, 400);
      endcase
      e = s + $urandom_range(0, 700);
      if ($urandom_range(0, 15) == 0) e = s - $urandom_range(1, 50);
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      lat = $urandom_range(0, 3);
      run_req(s, e, m, lat, 0, 1, got_err, got_cnt, k_done);
    end

    // Reset in WAIT of the second chunk of a die-1 request; last_die must return to 0.
    run_req(32'h02000000, 32'h020001FF, 2'd2, 0, 2, 1, got_err, got_cnt, k_done);
    check("midreset_flags", obs_s.size(), 2);
    system_reset_n = 1'b0;
    m_last_die = 0;
    #1;
    check_reset_vals("midreset");
    @(negedge system_clk);
    system_reset_n = 1'b1;
    @(negedge system_clk);
    run_req(32'h0, 32'hB, 2'd0, 1, 0, 1, got_err, got_cnt, k_done);
    check("post_reset_err", got_err, 0);
    check("post_reset_count", got_cnt, 1);
    if (obs_sw.size() > 0) check("post_reset_switch_die", obs_sw[0], 0);

`ifdef FLASH_SCHED_TIMEOUT_EN
    run_req(32'h0, 32'hB, 2'd0, -1, 0, 0, got_err, got_cnt, k_done);
    check("timeout_err", got_err, 1);
    check("timeout_count", got_cnt, 0);
    check("timeout_flags", obs_s.size(), 1);
    check("timeout_latency", k_done, 104);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
